// File: rtl/alu_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
//   Shared types and constants for the ALU-sharing arbiter slice.
//   - arb_state_t : arbiter FSM states
//   - ALU_SEL_*   : encodings of the ALU op-select pin
//   - CNT_W       : width of the ALU latency counter (covers ALU_LAT up to 4)
//   - id_w()      : requester-index width for a given requester count
// -----------------------------------------------------------------------------
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam logic ALU_SEL_ADD = 1'b0;
  localparam logic ALU_SEL_SUB = 1'b1;

  localparam int CNT_W = 3;

  // Index width for n requesters; never below 1 so vectors stay legal.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
//   Requester/response bus between the requesters and the ALU arbiter.
//   Parameters: N_REQ requesters, WIDTH-bit operands/result.
//   Signals:
//     req_valid[N_REQ]        requester -> arbiter, request valid
//     req_ready[N_REQ]        arbiter -> requester, one-hot accept pulse
//     req_a/req_b[N_REQ*W]    operands, requester i at [i*WIDTH +: WIDTH]
//     req_sel[N_REQ]          op select per requester
//     rsp_valid/rsp_ready     response handshake
//     rsp_id/rsp_data         requester index and ALU result of the response
//   Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 3
);

  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_sel;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_rr_pick
//   Combinational round-robin search. Starting at rr_ptr and wrapping modulo
//   N_REQ, returns the first requester whose req_valid is set.
//   Ports:
//     req_valid  in   N_REQ  request valid vector
//     rr_ptr     in   ID_W   highest-priority requester index
//     grant_vld  out  1      some requester is valid
//     grant_idx  out  ID_W   index of the selected requester (0 if none)
// -----------------------------------------------------------------------------
module alu_share_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             grant_vld,
  output logic [ID_W-1:0]  grant_idx
);

  logic [ID_W:0] cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // One extra bit so rr_ptr + k cannot overflow before the wrap.
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one registered ALU between N_REQ requesters. Round-robin grant,
//   one operation in flight, result returned tagged with the requester index.
//   Flow: IDLE (grant + latch operands) -> ISSUE (ALU_LAT cycles) ->
//         CAPTURE (sample alu_f) -> RESP (hold until rsp_ready) -> IDLE.
//   Ports:
//     clk          in   1      rising-edge clock
//     reset_n      in   1      asynchronous active-low reset
//     bus          slave       requester/response interface
//     alu_a/alu_b  out  WIDTH  operands to the ALU, held between issues
//     alu_select   out  1      op select to the ALU
//     alu_f        in   WIDTH  ALU result
//     busy         out  1      high whenever not IDLE
// -----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 3,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_share_arbiter_if.slave bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_select,
  input  logic [WIDTH-1:0]  alu_f,
  output logic              busy
);

  localparam int ID_W = id_w(N_REQ);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]  lat_cnt_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [WIDTH-1:0]  rsp_data_q;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;
  logic [N_REQ-1:0]  req_ready_d;
  logic [ID_W-1:0]   rr_ptr_next;

  alu_share_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // The winner becomes lowest priority: pointer moves just past it.
  assign rr_ptr_next = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);

  // Next-state and accept logic. req_ready depends only on req_valid,
  // rr_ptr and state, so there is no combinational path from rsp_ready.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    req_ready_d = '0;
    unique case (state_q)
      IDLE: begin
        if (reset_n && grant_vld) begin
          accept                 = 1'b1;
          req_ready_d[grant_idx] = 1'b1;
          state_d                = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_cnt_q == CNT_W'(ALU_LAT-1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lat_cnt_q  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;

      // Accept edge: operands go straight onto the ALU pins and stay there
      // until the next accept, so the ALU inputs never toggle while idle.
      if (accept) begin
        alu_a      <= bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
        alu_b      <= bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
        alu_select <= bus.req_sel[grant_idx];
        rsp_id_q   <= grant_idx;
        rr_ptr_q   <= rr_ptr_next;
        lat_cnt_q  <= '0;
      end

      // ALU latency window.
      if (state_q == ISSUE) begin
        lat_cnt_q <= lat_cnt_q + CNT_W'(1);
      end

      // Result sample edge.
      if (state_q == CAPTURE) begin
        rsp_data_q <= alu_f;
      end
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 3;
  localparam int ALU_LAT = 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] alu_a, alu_b, alu_f;
  logic             alu_select;
  logic             busy;

  alu_share_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(
    .N_REQ   (N_REQ),
    .WIDTH   (WIDTH),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_f      (alu_f),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Registered ALU model, result wraps mod 2^WIDTH.
  always @(posedge clk) begin
    if (alu_select == ALU_SEL_SUB) alu_f <= alu_a - alu_b;
    else                           alu_f <= alu_a + alu_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int id;
    int data;
  } rsp_t;

  int   gq[$];
  rsp_t rq[$];
  logic ivl_chk = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Grant monitor: every accept pulse must match the next expected grant.
  int last_acc = -1;
  always @(negedge clk) begin
    int g;
    if (!ivl_chk) last_acc = -1;
    if (reset_n && bus.req_ready != '0) begin
      g = -1;
      for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) g = i;
      check("grant_onehot", $countones(bus.req_ready), 1);
      if (gq.size() == 0) check("grant_unexpected", g, -1);
      else check("grant_idx", g, gq.pop_front());
      if (ivl_chk && last_acc >= 0) check("accept_interval", cyc - last_acc, ALU_LAT + 3);
      last_acc = cyc;
    end
  end

  // Response monitor: every completed handshake is scored against the queue.
  always @(negedge clk) begin
    rsp_t e;
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (rq.size() == 0) begin
        check("rsp_unexpected", int'(bus.rsp_id), -1);
      end else begin
        e = rq.pop_front();
        check("rsp_id", int'(bus.rsp_id), e.id);
        check("rsp_data", int'(bus.rsp_data), e.data);
      end
    end
  end

  task automatic drive_req(input int i, input int a, input int b, input int s);
    bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    bus.req_sel[i]              = s[0];
    bus.req_valid[i]            = 1'b1;
  endtask

  task automatic wait_grant_drop(input int i);
    int t;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.req_ready[i]) break;
    end
    if (t == 40) check("grant_timeout", i, -1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input int a, input int b, input int s, input int exp);
    @(posedge clk); #1;
    gq.push_back(i);
    rq.push_back('{i, exp});
    drive_req(i, a, b, s);
    wait_grant_drop(i);
  endtask

  task automatic wait_done();
    int t;
    for (t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (!busy && rq.size() == 0 && gq.size() == 0) break;
    end
    if (t == 60) check("done_timeout", rq.size() + gq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_alu_pins", {alu_a, alu_b, alu_select}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single request, latency to response
    @(posedge clk); #1;
    gq.push_back(0);
    rq.push_back('{0, 7});
    drive_req(0, 4, 3, 0);
    @(negedge clk);
    check("t2_ready_c0", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t2_rsp_c2_low", bus.rsp_valid, 0);
    @(negedge clk);
    check("t2_rsp_c3_high", bus.rsp_valid, 1);
    wait_done();

    // Subtract, including wrap-around
    issue(1, 3, 1, 1, 2);
    wait_done();
    issue(1, 1, 3, 1, 6);
    wait_done();

    // Async reset in the middle of ISSUE
    @(posedge clk); #1;
    gq.push_back(3);
    drive_req(3, 5, 2, 0);
    wait_grant_drop(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_busy", busy, 0);
    check("t1_alu_a", alu_a, 0);
    check("t1_alu_b", alu_b, 0);
    check("t1_rsp_id", bus.rsp_id, 0);
    check("t1_rsp_valid", bus.rsp_valid, 0);
    bus.req_valid[2] = 1'b1;
    #1;
    check("t1_ready_in_reset", bus.req_ready, 0);
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_no_rsp", {bus.rsp_valid, busy}, 0);
    end

    // All four valid and held: pointer restarts at 0 after reset
    @(posedge clk); #1;
    ivl_chk = 1'b1;
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
    rq.push_back('{0, 3}); rq.push_back('{1, 3}); rq.push_back('{2, 5});
    rq.push_back('{3, 6}); rq.push_back('{0, 3});
    drive_req(0, 1, 2, 0);
    drive_req(1, 5, 6, 0);
    drive_req(2, 2, 5, 1);
    drive_req(3, 7, 7, 0);
    for (t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (gq.size() == 0) break;
    end
    if (t == 200) check("t4_grant_timeout", gq.size(), 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    ivl_chk = 1'b0;
    wait_done();

    // Response back-pressure
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    gq.push_back(1); gq.push_back(3);
    rq.push_back('{1, 5}); rq.push_back('{3, 6});
    drive_req(1, 6, 1, 1);
    drive_req(3, 2, 4, 0);
    wait_grant_drop(1);
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    if (t == 20) check("t5_rsp_timeout", bus.rsp_valid, 1);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) @(negedge clk);
      check("t5_stall", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready, busy},
            {1'b1, 2'd1, 3'd5, 4'd0, 1'b1});
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_grant_drop(3);
    wait_done();

    // Request withdrawn while busy leaves the pointer alone
    @(posedge clk); #1;
    gq.push_back(0);
    rq.push_back('{0, 0});
    drive_req(0, 3, 3, 1);
    wait_grant_drop(0);
    bus.req_valid[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    wait_done();
    @(posedge clk); #1;
    gq.push_back(1); gq.push_back(0);
    rq.push_back('{1, 7}); rq.push_back('{0, 3});
    drive_req(0, 2, 1, 0);
    drive_req(1, 0, 1, 1);
    wait_grant_drop(1);
    wait_grant_drop(0);
    wait_done();

    check("queues_empty", gq.size() + rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
